// File: rtl/pem_frame_capture.sv
// PEM-synchronous frame capture: writes reference-synced samples to RAM over
// cfg_periods PEM periods, then reports success (trig_search) or failure (cap_fail).
module pem_frame_capture #(
  parameter int DW  = 16,
  parameter int AW  = 9,
  parameter int NCH = 2,
  parameter int PW  = 4
) (
  input  logic              alg_clk,
  input  logic              alg_rst,
  input  logic [NCH*DW-1:0] din,
  input  logic              din_valid,
  input  logic              pem_posedge,
  input  logic              frequency_detected,
  input  logic              refresh_align,
  input  logic [PW-1:0]     cfg_periods,
  input  logic [AW-1:0]     cfg_min_cnt,
  input  logic              cfg_continuous,
  output logic [NCH*DW-1:0] ram_dat,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_wr_valid,
  output logic              trig_search,
  output logic              cap_fail,
  output logic [AW-1:0]     period_len
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    CHECK,
    SUCCESS,
    FAIL,
    WAIT_ALIGN
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] cnt;
  logic [PW-1:0] per_cnt;
  logic [PW-1:0] per_next;
  logic          full;
  logic          short_f;
  logic          ovf_f;
  logic [PW-1:0] lat_periods;
  logic [AW-1:0] lat_min;
  logic          lat_cont;

  assign per_next = per_cnt + PW'(1);

  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      state        <= IDLE;
      ram_dat      <= '0;
      ram_addr     <= '0;
      ram_wr_valid <= 1'b0;
      trig_search  <= 1'b0;
      cap_fail     <= 1'b0;
      period_len   <= '0;
      addr         <= '0;
      cnt          <= '0;
      per_cnt      <= '0;
      full         <= 1'b0;
      short_f      <= 1'b0;
      ovf_f        <= 1'b0;
      lat_periods  <= '0;
      lat_min      <= '0;
      lat_cont     <= 1'b0;
    end else begin
      ram_wr_valid <= 1'b0;
      trig_search  <= 1'b0;
      cap_fail     <= 1'b0;
      if (state != IDLE && !frequency_detected) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (frequency_detected) state <= ARM;
          ARM: begin
            if (pem_posedge) begin
              state       <= CAPTURE;
              addr        <= '0;
              cnt         <= '0;
              per_cnt     <= '0;
              full        <= 1'b0;
              short_f     <= 1'b0;
              ovf_f       <= 1'b0;
              lat_periods <= (cfg_periods == '0) ? PW'(1) : cfg_periods;
              lat_min     <= cfg_min_cnt;
              lat_cont    <= cfg_continuous;
            end
          end
          CAPTURE: begin
            if (pem_posedge) begin
              period_len <= cnt;
              if (cnt < lat_min) short_f <= 1'b1;
              per_cnt <= per_next;
              full    <= 1'b0;
              if (per_next == lat_periods) begin
                state <= CHECK;
              end else if (din_valid) begin
                // a sample arriving with the edge opens the new period
                ram_wr_valid <= 1'b1;
                ram_dat      <= din;
                ram_addr     <= '0;
                addr         <= AW'(1);
                cnt          <= AW'(1);
              end else begin
                addr <= '0;
                cnt  <= '0;
              end
            end else if (din_valid) begin
              if (full) begin
                ovf_f <= 1'b1;
              end else begin
                ram_wr_valid <= 1'b1;
                ram_dat      <= din;
                ram_addr     <= addr;
                // the top address is written once; addr parks there, never wraps
                if (addr == ADDR_MAX) full <= 1'b1;
                else                  addr <= addr + AW'(1);
                if (cnt != ADDR_MAX) cnt <= cnt + AW'(1);
              end
            end
          end
          CHECK: begin
            if (short_f || ovf_f) begin
              state    <= FAIL;
              cap_fail <= 1'b1;
            end else begin
              state       <= SUCCESS;
              trig_search <= 1'b1;
            end
          end
          SUCCESS:    state <= lat_cont ? WAIT_ALIGN : IDLE;
          FAIL:       state <= ARM;
          WAIT_ALIGN: if (refresh_align) state <= ARM;
          default:    state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pem_frame_capture.sv
// Directed bench for pem_frame_capture: per-cycle scoreboard of expected writes,
// pulses and period lengths, plus hand-computed literal checkpoints.
module tb_pem_frame_capture;
  localparam int DW   = 16;
  localparam int AW   = 9;
  localparam int NCH  = 2;
  localparam int PW   = 4;
  localparam int AMAX = 1 << AW;

  logic              clk = 1'b0;
  logic              alg_rst;
  logic [NCH*DW-1:0] din;
  logic              din_valid;
  logic              pem_posedge;
  logic              frequency_detected;
  logic              refresh_align;
  logic [PW-1:0]     cfg_periods;
  logic [AW-1:0]     cfg_min_cnt;
  logic              cfg_continuous;
  logic [NCH*DW-1:0] ram_dat;
  logic [AW-1:0]     ram_addr;
  logic              ram_wr_valid;
  logic              trig_search;
  logic              cap_fail;
  logic [AW-1:0]     period_len;

  pem_frame_capture #(.DW(DW), .AW(AW), .NCH(NCH), .PW(PW)) dut (
    .alg_clk            (clk),
    .alg_rst            (alg_rst),
    .din                (din),
    .din_valid          (din_valid),
    .pem_posedge        (pem_posedge),
    .frequency_detected (frequency_detected),
    .refresh_align      (refresh_align),
    .cfg_periods        (cfg_periods),
    .cfg_min_cnt        (cfg_min_cnt),
    .cfg_continuous     (cfg_continuous),
    .ram_dat            (ram_dat),
    .ram_addr           (ram_addr),
    .ram_wr_valid       (ram_wr_valid),
    .trig_search        (trig_search),
    .cap_fail           (cap_fail),
    .period_len         (period_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_wr = 0;
  int n_trig = 0;
  int n_fail = 0;

  // Expectations keyed by the clock-edge number after which they are visible
  bit                exp_wr   [int];
  logic [AW-1:0]     exp_addr [int];
  logic [NCH*DW-1:0] exp_dat  [int];
  bit                exp_trig [int];
  bit                exp_fail [int];
  int                exp_plen [int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ram_wr_valid", 64'(ram_wr_valid), 64'(exp_wr.exists(cyc)));
      if (ram_wr_valid === 1'b1) n_wr++;
      if (exp_wr.exists(cyc)) begin
        chk("ram_addr", 64'(ram_addr), 64'(exp_addr[cyc]));
        chk("ram_dat", 64'(ram_dat), 64'(exp_dat[cyc]));
      end
      chk("trig_search", 64'(trig_search), 64'(exp_trig.exists(cyc)));
      chk("cap_fail", 64'(cap_fail), 64'(exp_fail.exists(cyc)));
      if (trig_search === 1'b1) n_trig++;
      if (cap_fail === 1'b1) n_fail++;
      if (exp_plen.exists(cyc)) chk("period_len", 64'(period_len), 64'(exp_plen[cyc]));
    end
  end

  task automatic drive(input bit v, input logic [NCH*DW-1:0] d, input bit pe, input bit ra = 1'b0);
    din_valid     = v;
    din           = d;
    pem_posedge   = pe;
    refresh_align = ra;
    @(posedge clk);
    #1;
  endtask

  // Sample j of a period lands at address j while it fits in the RAM
  task automatic put_sample(input int j, input bit pe);
    logic [NCH*DW-1:0] d;
    int c;
    d = $urandom;
    c = cyc + 1;
    if (j < AMAX) begin
      exp_wr[c]   = 1'b1;
      exp_addr[c] = j[AW-1:0];
      exp_dat[c]  = d;
    end
    drive(1'b1, d, pe);
  endtask

  task automatic run_frame(input int np, input int lens[4], input int minc, input bit cont,
                           input bit coin_mid, input bit coin_final);
    int c;
    int eff;
    int first;
    bit bad;
    bad = 1'b0;
    c   = 0;
    eff = (np == 0) ? 1 : np;
    cfg_periods    = PW'(np);
    cfg_min_cnt    = AW'(minc);
    cfg_continuous = cont;
    drive(1'b0, '0, 1'b1);
    // config may change freely once the frame has started
    cfg_periods    = PW'(eff + 1);
    cfg_min_cnt    = '1;
    cfg_continuous = !cont;
    for (int p = 0; p < eff; p++) begin
      first = (p > 0 && coin_mid) ? 1 : 0;
      for (int j = first; j < lens[p]; j++) begin
        if (j % 9 == 4) drive(1'b0, '0, 1'b0);
        put_sample(j, 1'b0);
      end
      if (lens[p] < minc || lens[p] > AMAX) bad = 1'b1;
      c = cyc + 1;
      if (lens[p] < AMAX) exp_plen[c] = lens[p];
      if (p == eff - 1)  drive(coin_final, $urandom, 1'b1);
      else if (coin_mid) put_sample(0, 1'b1);
      else               drive(1'b0, '0, 1'b1);
    end
    if (bad) exp_fail[c + 1] = 1'b1;
    else     exp_trig[c + 1] = 1'b1;
    repeat (4) drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    alg_rst = 1'b1;
    frequency_detected = 1'b0;
    cfg_periods = '0;
    cfg_min_cnt = '0;
    cfg_continuous = 1'b0;
    drive(1'b0, '0, 1'b0);
    chk_en = 1'b1;
    repeat (2) drive(1'b0, '0, 1'b0);
    chk("reset ram_addr", 64'(ram_addr), 64'd0);
    chk("reset ram_dat", 64'(ram_dat), 64'd0);
    chk("reset period_len", 64'(period_len), 64'd0);
    chk("reset ram_wr_valid", 64'(ram_wr_valid), 64'd0);

    alg_rst = 1'b0;
    frequency_detected = 1'b1;
    repeat (2) drive(1'b0, '0, 1'b0);

    // three good periods of 120, single-shot
    run_frame(3, '{120, 120, 120, 0}, 100, 1'b0, 1'b0, 1'b0);
    chk("frameA writes", 64'(n_wr), 64'd360);
    chk("frameA trig", 64'(n_trig), 64'd1);
    chk("frameA period_len", 64'(period_len), 64'd120);

    // short middle period -> failure and automatic re-arm
    run_frame(3, '{120, 80, 120, 0}, 100, 1'b0, 1'b0, 1'b0);
    chk("frameB fail", 64'(n_fail), 64'd1);
    chk("frameB trig", 64'(n_trig), 64'd1);

    // coincident samples on mid and final edges, continuous mode
    run_frame(2, '{110, 105, 0, 0}, 100, 1'b1, 1'b1, 1'b1);
    chk("frameC writes", 64'(n_wr), 64'd895);
    chk("frameC trig", 64'(n_trig), 64'd2);

    // parked in WAIT_ALIGN: edges and samples ignored until refresh_align
    repeat (3) drive(1'b1, $urandom, 1'b1);
    chk("wait_align no writes", 64'(n_wr), 64'd895);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0);

    // cfg_periods=0 acts as one period
    run_frame(0, '{101, 0, 0, 0}, 100, 1'b0, 1'b0, 1'b0);
    chk("frameD trig", 64'(n_trig), 64'd3);
    chk("frameD period_len", 64'(period_len), 64'd101);

    // overflow: 520 samples into a 512-entry RAM
    run_frame(1, '{520, 0, 0, 0}, 100, 1'b0, 1'b0, 1'b0);
    chk("frameE fail", 64'(n_fail), 64'd2);
    chk("frameE last addr", 64'(ram_addr), 64'(AMAX - 1));
    chk("frameE writes", 64'(n_wr), 64'd1508);

    // lock lost mid-capture: no write that cycle, back through IDLE
    cfg_periods = 4'd3;
    cfg_min_cnt = 9'd100;
    drive(1'b0, '0, 1'b1);
    for (int j = 0; j < 20; j++) put_sample(j, 1'b0);
    frequency_detected = 1'b0;
    drive(1'b1, $urandom, 1'b0);
    drive(1'b0, '0, 1'b0);
    frequency_detected = 1'b1;
    repeat (2) drive(1'b0, '0, 1'b0);
    repeat (5) drive(1'b1, $urandom, 1'b0);
    chk("lock drop writes", 64'(n_wr), 64'd1528);

    // reset mid-frame
    drive(1'b0, '0, 1'b1);
    for (int j = 0; j < 10; j++) put_sample(j, 1'b0);
    alg_rst = 1'b1;
    drive(1'b1, $urandom, 1'b1);
    drive(1'b1, $urandom, 1'b0);
    chk("midreset ram_addr", 64'(ram_addr), 64'd0);
    chk("midreset ram_dat", 64'(ram_dat), 64'd0);
    chk("midreset period_len", 64'(period_len), 64'd0);
    alg_rst = 1'b0;
    repeat (4) drive(1'b0, '0, 1'b0);
    chk("total writes", 64'(n_wr), 64'd1538);
    chk("total trig", 64'(n_trig), 64'd3);
    chk("total fail", 64'(n_fail), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
